// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared types and encodings for the PIM memory arbiter
package pim_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic REQ_CU   = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // A write request wins when read and write are both raised.
  function automatic logic req_op(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/pim_rr_pick.sv
// rtl/pim_rr_pick.sv - combinational 2-way round-robin picker
module pim_rr_pick
  import pim_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr_ptr,
  output logic       o_valid,
  output logic       o_id
);

  assign o_valid = |i_req;
  assign o_id    = (i_req == 2'b11) ? i_rr_ptr : (i_req[1] ? REQ_HOST : REQ_CU);

endmodule

// File: rtl/pim_mem_arbiter.sv
// rtl/pim_mem_arbiter.sv - round-robin arbiter sharing one PIM Memory between CU and host
module pim_mem_arbiter
  import pim_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write,
  output logic              mem_read,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_id;
  logic              r_op;
  logic              r_rr_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_read;
  logic              r_write;
  logic              r_busy;
  logic [1:0]        r_done;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_req;
  logic              w_valid;
  logic              w_id;
  logic              w_op;

  assign w_req = {r1_read | r1_write, r0_read | r0_write};
  assign w_op  = w_id ? req_op(r1_write) : req_op(r0_write);

  pim_rr_pick u_pick (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_valid),
    .o_id     (w_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_id     <= REQ_CU;
      r_op     <= OP_READ;
      r_rr_ptr <= REQ_CU;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            // Strobes go out together with the latched request so they are visible in ISSUE.
            r_id    <= w_id;
            r_op    <= w_op;
            r_addr  <= w_id ? r1_addr : r0_addr;
            r_wdata <= w_id ? r1_wdata : r0_wdata;
            r_read  <= (w_op == OP_READ);
            r_write <= (w_op == OP_WRITE);
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ready) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_done[r_id] <= 1'b1;
            if (r_op == OP_READ) begin
              if (r_id == REQ_HOST) r_rdata1 <= mem_data_out;
              else                  r_rdata0 <= mem_data_out;
            end
            r_state <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_err[r_id] <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_rr_ptr <= ~r_id;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign r0_rdata    = r_rdata0;
  assign r1_rdata    = r_rdata1;
  assign r0_done     = r_done[0];
  assign r1_done     = r_done[1];
  assign r0_err      = r_err[0];
  assign r1_err      = r_err[1];
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_read    = r_read;
  assign mem_write   = r_write;
  assign busy        = r_busy;
  assign grant_id    = r_id;

endmodule

// File: tb/tb_pim_mem_arbiter.sv
// tb/tb_pim_mem_arbiter.sv - self-checking bench for pim_mem_arbiter
module tb_pim_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          r0_done, r0_err, r1_done, r1_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_write, mem_read, mem_ready, busy, grant_id;

  always #5 clk = ~clk;

  pim_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_done(r0_done), .r0_err(r0_err),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write(mem_write), .mem_read(mem_read), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  // Reference: pending request per requester, priority pointer, memory image, last read data.
  bit            pv [2];
  bit            pw [2];
  bit            pb [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  int            rr;
  logic [DW-1:0] mrd [2];
  logic [DW-1:0] mem_model [0:1023];
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_reqs();
    r0_write = pv[0] & pw[0];
    r0_read  = pv[0] & (~pw[0] | pb[0]);
    r1_write = pv[1] & pw[1];
    r1_read  = pv[1] & (~pw[1] | pb[1]);
    r0_addr  = pv[0] ? pa[0] : AW'($urandom());
    r1_addr  = pv[1] ? pa[1] : AW'($urandom());
    r0_wdata = pv[0] ? pd[0] : $urandom();
    r1_wdata = pv[1] ? pd[1] : $urandom();
  endtask

  task automatic set_req(input int i, input bit w, input bit both,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[i] = 1'b1; pw[i] = w; pb[i] = both & w; pa[i] = a; pd[i] = d;
    drive_reqs();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_r0_rdata"}, 64'(r0_rdata), 64'(0));
    chk({tag, "_r1_rdata"}, 64'(r1_rdata), 64'(0));
    chk({tag, "_pulses"}, 64'({r0_done, r1_done, r0_err, r1_err}), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_address), 64'(0));
    chk({tag, "_mem_din"}, 64'(mem_data_in), 64'(0));
    chk({tag, "_strobes"}, 64'({mem_write, mem_read}), 64'(0));
    chk({tag, "_busy_gid"}, 64'({busy, grant_id}), 64'(0));
  endtask

  // Serves one grant. lat: strobe cycle (from 1) in which memory raises ready; 0 = never.
  // Returns at the negedge of the response cycle with the request of the served id dropped.
  task automatic do_grant(input int lat, input int exp_gap);
    int id, gap, k;
    bit seen, hang, held_ok;
    hang = (lat == 0);
    id   = (pv[0] && pv[1]) ? rr : (pv[1] ? 1 : 0);
    gap  = 0;
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk);
      if (mem_read | mem_write) seen = 1'b1;
      else begin
        gap++;
        chk("idle_pulses", 64'({r0_done, r1_done, r0_err, r1_err}), 64'(0));
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("strobe_seen", 64'(seen), 64'(1));
    if (!seen) return;
    if (exp_gap >= 0) chk("grant_gap", 64'(gap), 64'(exp_gap));
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("busy_issue", 64'(busy), 64'(1));
    chk("strobe_kind", 64'({mem_write, mem_read}), pw[id] ? 64'(2) : 64'(1));
    chk("mem_addr", 64'(mem_address), 64'(pa[id]));
    if (pw[id]) chk("mem_wdata", 64'(mem_data_in), 64'(pd[id]));
    held_ok = 1'b1;
    k = 1;
    while ((mem_read | mem_write) && k <= TO + 4) begin
      held_ok &= (mem_address == pa[id]) && busy && (grant_id == 1'(id));
      mem_ready    = (k == 1) ? 1'($urandom_range(0, 1)) : (!hang && k == lat);
      mem_data_out = (!pw[id] && k == lat) ? mem_model[pa[id]] : $urandom();
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    chk("strobe_len", 64'(k - 1), hang ? 64'(TO + 1) : 64'(lat));
    chk("strobe_held", 64'(held_ok), 64'(1));
    if (!hang) begin
      if (pw[id]) mem_model[pa[id]] = pd[id];
      else        mrd[id] = mem_model[pa[id]];
    end
    chk("done", 64'({r1_done, r0_done}), hang ? 64'(0) : 64'(id == 1 ? 2 : 1));
    chk("err", 64'({r1_err, r0_err}), hang ? 64'(id == 1 ? 2 : 1) : 64'(0));
    chk("r0_rdata", 64'(r0_rdata), 64'(mrd[0]));
    chk("r1_rdata", 64'(r1_rdata), 64'(mrd[1]));
    chk("busy_resp", 64'(busy), 64'(0));
    rr = (id == 0) ? 1 : 0;
    pv[id] = 1'b0;
    drive_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pw[i] = 0; pb[i] = 0; pa[i] = '0; pd[i] = '0; mrd[i] = '0;
    end
    rr = 0;
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_data_out = '0;
    drive_reqs();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed write then read-back on the CU port.
    set_req(0, 1'b1, 1'b0, 10'h38A, 32'h12345678);
    do_grant(3, 0);
    set_req(0, 1'b0, 1'b0, 10'h38A, 32'h0);
    do_grant(2, 1);
    chk("readback", 64'(r0_rdata), 64'h12345678);

    // Host alone: three back-to-back writes (one with read also raised).
    for (int n = 0; n < 3; n++) begin
      set_req(1, 1'b1, (n == 1), AW'(10'h100 + n), 32'hA0000000 + n);
      do_grant(2 + n, (n == 0) ? -1 : 1);
    end
    set_req(0, 1'b0, 1'b0, 10'h101, 32'h0);
    set_req(1, 1'b0, 1'b0, 10'h102, 32'h0);
    do_grant(2, 1);
    chk("dual_after_host", 64'(rr), 64'(1));
    do_grant(2, -1);

    // Hung memory: abort after TIMEOUT wait cycles, then a normal request.
    set_req(0, 1'b0, 1'b0, 10'h38A, 32'h0);
    do_grant(0, 1);
    set_req(0, 1'b0, 1'b0, 10'h100, 32'h0);
    do_grant(4, 1);

    // Reset while waiting; dual requests afterwards start with the CU.
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 10'h155, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_rst_strobe", 64'(mem_read), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    rr = 0;
    mrd[0] = '0; mrd[1] = '0;
    set_req(0, 1'b0, 1'b0, 10'h001, 32'h0);
    set_req(1, 1'b0, 1'b0, 10'h002, 32'h0);
    for (int n = 0; n < 4; n++) begin
      do_grant(2 + (n % 3), (n == 0) ? 0 : 1);
      if (n % 2 == 0) set_req(0, 1'b0, 1'b0, 10'h001, 32'h0);
      else            set_req(1, 1'b0, 1'b0, 10'h002, 32'h0);
    end
    do_grant(2, 1);
    do_grant(2, 1);

    // Randomized traffic against the reference.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'(10'h3F0 + $urandom_range(0, 3)), $urandom());
      if (!pv[0] && !pv[1])
        set_req(int'($urandom_range(0, 1)), 1'b1, 1'b0, AW'(10'h3F0 + $urandom_range(0, 3)), $urandom());
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 6));
      do_grant(lat, -1);
    end
    while (pv[0] || pv[1]) do_grant(2, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
